game_step_scheduler: RTL
========================

// Module: game_step_scheduler
// PURPOSE
//  Sequences the snake game core: owns the game FSM (start/run/pause/over) and the step timer, and issues one-cycle step pulses.
//  Buffers button directions in a small queue, rejecting repeats and reversals, so quick turns between steps are not lost.
//  Applies the speed ramp on each eaten dot. Sits between the input decoder and the board-update logic.
// PARAMETERS
//  START_SPEED   2500000  clk cycles per step after start/restart
//  MIN_SPEED     500000   floor for the step period (cycles)
//  DIR_Q_DEPTH   2        direction queue entries (power of two, >=2)
// PORTS
//  clk         in   1   system clock
//  hard_reset  in   1   synchronous, active-high reset
//  start_req   in   1   one-cycle pulse: start from IDLE or restart from OVER
//  pause_btn   in   1   one-cycle pulse: toggle pause (PAUSE_EN only)
//  dir_valid   in   1   dir_in valid this cycle
//  dir_in      in   2   0=up 1=left 2=down 3=right
//  dot_eaten   in   1   pulse from core: head consumed a dot
//  crash       in   1   pulse from core: wall/self collision
//  step        out  1   one-cycle pulse: advance the snake one square
//  step_dir    out  2   direction for this step (held between steps)
//  state       out  2   0=IDLE 1=RUN 2=PAUSE 3=OVER
//  period      out  31  current cycles per step
//  q_count     out  clog2(DIR_Q_DEPTH)+1  queued directions
// BEHAVIOUR
//  Reset: state=IDLE, step=0, step_dir=0, cur_dir=0, period=START_SPEED, cnt=0, queue empty.
//  hard_reset has priority over all inputs at every state. Reset mid-run aborts the run with no step pulse.
//  IDLE/OVER: start_req -> RUN next cycle.
//    Restart loads cnt=0, period=START_SPEED, cur_dir=step_dir=0 and flushes the queue.
//    In IDLE/OVER: cnt frozen, dir_valid/dot_eaten/crash ignored.
//  RUN: cnt increments each cycle. When cnt==period-1: step=1 for one cycle, cnt<=0.
//    Dir source: pop queue head if non-empty, else cur_dir. step_dir and cur_dir take the popped value (visible with step).
//    First step comes exactly START_SPEED cycles after the start_req cycle.
//  Enqueue (RUN and PAUSE): ref = last queued entry if the queue is non-empty, else cur_dir.
//    Accept iff queue not full, dir_in!=ref and dir_in!=(ref^2). Otherwise drop silently.
//  Enqueue+pop same cycle: both happen and q_count is unchanged. A direction entered in a step cycle never bypasses to that step.
//  dot_eaten (RUN): period <= max(MIN_SPEED, period - (period*3)>>8).
//    The product is computed at 33 bits with no truncation before the shift. Takes effect from the next cnt compare.
//  crash (RUN or PAUSE): state<=OVER. crash beats step: no step pulse in the crash cycle, cnt frozen.
//    crash beats dot_eaten: period is not updated.
//  start_req in RUN/PAUSE: ignored.
//  step is never asserted outside RUN and is never asserted on consecutive cycles (period>=2 required).
// CONFIGURATION
//  PAUSE_EN defined: in RUN, pause_btn -> PAUSE with cnt held. In PAUSE, pause_btn -> RUN and counting resumes from the held cnt.
//    A step due in the pause_btn cycle is suppressed and deferred. Queue stays intact.
//  PAUSE_EN undefined: pause_btn ignored, state never 2.
// TESTING  (bench: START_SPEED=10, MIN_SPEED=8 unless noted)
//  1 reset, start_req@t0 -> state=1@t0+1; step at t0+10, t0+20, t0+30; step_dir=0.
//  2 RUN, q empty, dir 3 then dir 1 before next step -> q_count=1; steps give step_dir=3, then 3.
//  3 cur_dir=0, dir_valid with dir_in=2, then dir_in=0 -> both rejected, q_count stays 0.
//  4 START_SPEED=1000, MIN_SPEED=980, three dot_eaten pulses -> period 989, 978->clamped 980, 980.
//  5 crash in the same cycle cnt==period-1 -> state=3, no step. Then start_req -> RUN, period=10, q_count=0.
//  6 PAUSE_EN: pause_btn at cnt=4 -> PAUSE with cnt=4 held 20 cycles. pause_btn -> next step 6 cycles later.
//    Without PAUSE_EN: same stimulus, steps unaffected.

Source files
------------

// File: rtl/game_step_scheduler_if.sv
// Handshake bundle between the input decoder / board core and game_step_scheduler.
// master drives buttons and core events; slave (the scheduler) returns step timing.
interface game_step_scheduler_if #(
    parameter int DIR_Q_DEPTH = 2
);
    localparam int QW = $clog2(DIR_Q_DEPTH) + 1;

    logic          start_req;
    logic          pause_btn;
    logic          dir_valid;
    logic [1:0]    dir_in;
    logic          dot_eaten;
    logic          crash;
    logic          step;
    logic [1:0]    step_dir;
    logic [1:0]    state;
    logic [30:0]   period;
    logic [QW-1:0] q_count;

    modport master (
        output start_req, pause_btn, dir_valid, dir_in, dot_eaten, crash,
        input  step, step_dir, state, period, q_count
    );

    modport slave (
        input  start_req, pause_btn, dir_valid, dir_in, dot_eaten, crash,
        output step, step_dir, state, period, q_count
    );
endinterface

// File: rtl/game_step_scheduler.sv
// Snake game sequencer: game FSM, step timer, buffered turn queue and speed ramp.
// Define PAUSE_EN to enable the pause_btn RUN<->PAUSE toggle; otherwise pause_btn is ignored.
module game_step_scheduler #(
    parameter int START_SPEED = 2500000,
    parameter int MIN_SPEED   = 500000,
    parameter int DIR_Q_DEPTH = 2
) (
    input logic                  clk,
    input logic                  hard_reset,
    game_step_scheduler_if.slave bus
);
    localparam int AW = $clog2(DIR_Q_DEPTH);
    localparam int QW = AW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;

    state_t        st_q, st_d;
    logic [30:0]   cnt_q, period_q, period_dec, period_sub, period_nxt;
    logic [32:0]   prod;
    logic [1:0]    cur_dir_q, ref_dir, step_dir;
    logic [1:0]    mem_q [DIR_Q_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [QW-1:0] count_q;
    logic          pause_hit, due, step, pop, push, restart, active;

`ifdef PAUSE_EN
    assign pause_hit = bus.pause_btn;
`else
    logic unused_pause;
    assign unused_pause = bus.pause_btn;
    assign pause_hit    = 1'b0;
`endif

    assign active  = (st_q == RUN) || (st_q == PAUSE);
    assign restart = ((st_q == IDLE) || (st_q == OVER)) && bus.start_req;
    // >= so a period shortened below the running count still steps at once
    assign due     = (st_q == RUN) && (cnt_q >= period_q - 31'd1);

    always_ff @(posedge clk) begin
        if (hard_reset) st_q <= IDLE;
        else            st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE, OVER: if (bus.start_req) st_d = RUN;
            RUN:        if (bus.crash) st_d = OVER; else if (pause_hit) st_d = PAUSE;
            PAUSE:      if (bus.crash) st_d = OVER; else if (pause_hit) st_d = RUN;
            default:    st_d = IDLE;
        endcase
    end

    // Crash and a pause toggle both swallow a due step; the count is held for resume.
    always_comb begin
        step     = due && !bus.crash && !pause_hit && !hard_reset;
        pop      = step && (count_q != '0);
        step_dir = pop ? mem_q[rd_ptr_q] : cur_dir_q;
    end

    assign bus.step     = step;
    assign bus.step_dir = step_dir;
    assign bus.state    = st_q;
    assign bus.period   = period_q;
    assign bus.q_count  = count_q;

    // Compare against the newest queued turn so a burst of presses cannot reverse the snake.
    always_comb begin
        ref_dir = (count_q != '0) ? mem_q[wr_ptr_q - AW'(1)] : cur_dir_q;
        push    = active && bus.dir_valid && (count_q != QW'(DIR_Q_DEPTH)) &&
                  (bus.dir_in != ref_dir) && (bus.dir_in != (ref_dir ^ 2'd2));
    end

    always_comb begin
        prod       = {2'b00, period_q} * 33'd3;
        period_dec = 31'(prod >> 8);
        period_sub = period_q - period_dec;
        period_nxt = (period_sub < 31'(MIN_SPEED)) ? 31'(MIN_SPEED) : period_sub;
    end

    always_ff @(posedge clk) begin
        if (hard_reset || restart) begin
            cnt_q     <= '0;
            period_q  <= 31'(START_SPEED);
            cur_dir_q <= 2'd0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            if (st_q == RUN && !bus.crash && !pause_hit)
                cnt_q <= due ? '0 : cnt_q + 31'd1;
            if (st_q == RUN && bus.dot_eaten && !bus.crash)
                period_q <= period_nxt;
            if (step)
                cur_dir_q <= step_dir;
            if (push) begin
                mem_q[wr_ptr_q] <= bus.dir_in;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + QW'(1);
                2'b01:   count_q <= count_q - QW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
